// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory access arbiter: FSM state encoding and
// the port-select codes used when latching the winning request.
package dmem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CPU_ACC  = 3'd1,
    CPU_DONE = 3'd2,
    DBG_ACC  = 3'd3,
    DBG_DONE = 3'd4
  } arb_state_t;

  localparam logic SEL_CPU = 1'b0;
  localparam logic SEL_DBG = 1'b1;

endpackage

// File: rtl/dmem_latency_counter.sv
// Access-phase cycle counter: held at zero while cleared, counts while enabled,
// and flags the last cycle of a MEM_LATENCY-long access.
module dmem_latency_counter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign done = (count == CW'(MEM_LATENCY - 1));

endmodule

// File: rtl/dmem_access_arbiter.sv
// Shares one single-port data memory between the MEM stage and a debug port,
// holding each command for MEM_LATENCY cycles with starvation-bounded priority.
module dmem_access_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_MemRead,
  input  logic                  cpu_MemWrite,
  input  logic [ADDR_WIDTH-1:0] cpu_Address,
  input  logic [DATA_WIDTH-1:0] cpu_WriteData,
  output logic [DATA_WIDTH-1:0] cpu_ReadData,
  output logic                  cpu_Stall,
  input  logic                  dbg_Req,
  input  logic                  dbg_Write,
  input  logic [ADDR_WIDTH-1:0] dbg_Address,
  input  logic [DATA_WIDTH-1:0] dbg_WriteData,
  output logic [DATA_WIDTH-1:0] dbg_ReadData,
  output logic                  dbg_Ack,
  output logic                  mem_Read,
  output logic                  mem_Write,
  output logic [ADDR_WIDTH-1:0] mem_Address,
  output logic [DATA_WIDTH-1:0] mem_WriteData,
  input  logic [DATA_WIDTH-1:0] mem_ReadData
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t            state;
  logic [SW-1:0]         starve_cnt;
  logic                  cpu_req;
  logic                  starved;
  logic                  grant_any;
  logic                  grant_sel;
  logic                  grant_write;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0] grant_wdata;
  logic                  in_acc;
  logic                  in_dbg;
  logic                  lat_done;

  // A simultaneous read+write from the MEM stage is treated as a write.
  assign cpu_req   = cpu_MemRead | cpu_MemWrite;
  assign cpu_Stall = cpu_req & (state != CPU_DONE);

  assign starved     = (starve_cnt >= SW'(STARVE_LIMIT));
  assign grant_any   = cpu_req | dbg_Req;
  assign grant_sel   = (dbg_Req && (starved || !cpu_req)) ? SEL_DBG : SEL_CPU;
  assign grant_write = (grant_sel == SEL_DBG) ? dbg_Write     : cpu_MemWrite;
  assign grant_addr  = (grant_sel == SEL_DBG) ? dbg_Address   : cpu_Address;
  assign grant_wdata = (grant_sel == SEL_DBG) ? dbg_WriteData : cpu_WriteData;

  assign in_acc = (state == CPU_ACC) || (state == DBG_ACC);
  assign in_dbg = (state == DBG_ACC) || (state == DBG_DONE);

  dmem_latency_counter #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_latency (
    .clock (clock),
    .reset (reset),
    .clear (!in_acc),
    .enable(in_acc),
    .done  (lat_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      mem_Read      <= 1'b0;
      mem_Write     <= 1'b0;
      mem_Address   <= '0;
      mem_WriteData <= '0;
      cpu_ReadData  <= '0;
      dbg_ReadData  <= '0;
      dbg_Ack       <= 1'b0;
    end else begin
      dbg_Ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            state         <= (grant_sel == SEL_DBG) ? DBG_ACC : CPU_ACC;
            mem_Address   <= grant_addr;
            mem_WriteData <= grant_wdata;
            mem_Read      <= !grant_write;
            mem_Write     <= grant_write;
          end
        end
        CPU_ACC: begin
          if (lat_done) begin
            if (mem_Read) cpu_ReadData <= mem_ReadData;
            mem_Read  <= 1'b0;
            mem_Write <= 1'b0;
            state     <= CPU_DONE;
          end
        end
        DBG_ACC: begin
          if (lat_done) begin
            if (mem_Read) dbg_ReadData <= mem_ReadData;
            mem_Read  <= 1'b0;
            mem_Write <= 1'b0;
            dbg_Ack   <= 1'b1;
            state     <= DBG_DONE;
          end
        end
        CPU_DONE: state <= IDLE;
        DBG_DONE: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Waiting debug cycles saturate at the limit; a debug grant restarts the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE && grant_any && grant_sel == SEL_DBG) begin
      starve_cnt <= '0;
    end else if (dbg_Req && !in_dbg && !starved) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Bench for dmem_access_arbiter: a latency-2 and a latency-1 instance, each with
// a behavioural memory, checked every cycle against a transaction-level model.
module tb_dmem_access_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst       [2];
  logic        cpu_rd    [2];
  logic        cpu_wr    [2];
  logic [31:0] cpu_addr  [2];
  logic [31:0] cpu_wdata [2];
  logic [31:0] cpu_rdata [2];
  logic        cpu_stall [2];
  logic        dbg_req   [2];
  logic        dbg_wr    [2];
  logic [31:0] dbg_addr  [2];
  logic [31:0] dbg_wdata [2];
  logic [31:0] dbg_rdata [2];
  logic        dbg_ack   [2];
  logic        mem_rd    [2];
  logic        mem_wr    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic [31:0] mem_arr   [2][16];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      dmem_access_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MEM_LATENCY ((gi == 0) ? 2 : 1),
        .STARVE_LIMIT(4)
      ) u_dut (
        .clock        (clk),
        .reset        (rst[gi]),
        .cpu_MemRead  (cpu_rd[gi]),
        .cpu_MemWrite (cpu_wr[gi]),
        .cpu_Address  (cpu_addr[gi]),
        .cpu_WriteData(cpu_wdata[gi]),
        .cpu_ReadData (cpu_rdata[gi]),
        .cpu_Stall    (cpu_stall[gi]),
        .dbg_Req      (dbg_req[gi]),
        .dbg_Write    (dbg_wr[gi]),
        .dbg_Address  (dbg_addr[gi]),
        .dbg_WriteData(dbg_wdata[gi]),
        .dbg_ReadData (dbg_rdata[gi]),
        .dbg_Ack      (dbg_ack[gi]),
        .mem_Read     (mem_rd[gi]),
        .mem_Write    (mem_wr[gi]),
        .mem_Address  (mem_addr[gi]),
        .mem_WriteData(mem_wdata[gi]),
        .mem_ReadData (mem_rdata[gi])
      );
      assign mem_rdata[gi] = mem_arr[gi][mem_addr[gi][5:2]];
    end
  endgenerate

  // Memory contents return to a known pattern whenever its arbiter is reset.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        for (int j = 0; j < 16; j++) mem_arr[k][j] <= 32'hA000 + 32'(j);
      end else if (mem_wr[k]) begin
        mem_arr[k][mem_addr[k][5:2]] <= mem_wdata[k];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Transaction-level model: owner 0 = none, 1 = cpu, 2 = debug; m_t counts
  // cycles since the grant (1..lat = command on the bus, lat+1 = done cycle).
  int          m_owner [2];
  int          m_t     [2];
  int          m_sc    [2];
  bit          m_armed [2];
  logic        m_kwr   [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdval [2];
  logic [31:0] m_cpu_rd[2];
  logic [31:0] m_dbg_rd[2];
  logic [31:0] m_mem   [2][16];

  task automatic model_cycle(input int k);
    int    lat;
    logic  creq, dreq, e_rd, e_wr, e_stall, e_ack;
    string tag;
    lat  = (k == 0) ? 2 : 1;
    tag  = $sformatf("u%0d", k);
    creq = cpu_rd[k] | cpu_wr[k];
    dreq = dbg_req[k];
    if (m_armed[k]) begin
      e_rd = 1'b0; e_wr = 1'b0; e_stall = creq; e_ack = 1'b0;
      if (m_owner[k] != 0 && m_t[k] <= lat) begin
        e_rd = !m_kwr[k];
        e_wr = m_kwr[k];
        chk({tag, " mem_addr"}, mem_addr[k], m_addr[k]);
        if (m_kwr[k]) chk({tag, " mem_wdata"}, mem_wdata[k], m_wdata[k]);
      end
      if (m_owner[k] != 0 && m_t[k] == lat + 1) begin
        if (m_owner[k] == 1) e_stall = 1'b0;
        else e_ack = 1'b1;
      end
      chk({tag, " mem_rd"},    32'(mem_rd[k]),    32'(e_rd));
      chk({tag, " mem_wr"},    32'(mem_wr[k]),    32'(e_wr));
      chk({tag, " cpu_stall"}, 32'(cpu_stall[k]), 32'(e_stall));
      chk({tag, " dbg_ack"},   32'(dbg_ack[k]),   32'(e_ack));
      chk({tag, " cpu_rdata"}, cpu_rdata[k], m_cpu_rd[k]);
      chk({tag, " dbg_rdata"}, dbg_rdata[k], m_dbg_rd[k]);
    end
    if (rst[k]) begin
      m_armed[k] = 1'b1; m_owner[k] = 0; m_t[k] = 0; m_sc[k] = 0;
      m_cpu_rd[k] = '0; m_dbg_rd[k] = '0;
      for (int j = 0; j < 16; j++) m_mem[k][j] = 32'hA000 + 32'(j);
    end else if (m_armed[k]) begin
      if (m_owner[k] == 0) begin
        if (dreq && (m_sc[k] >= 4 || !creq)) begin
          m_owner[k] = 2; m_sc[k] = 0;
          m_kwr[k] = dbg_wr[k]; m_addr[k] = dbg_addr[k]; m_wdata[k] = dbg_wdata[k];
        end else begin
          if (dreq && m_sc[k] < 4) m_sc[k]++;
          if (creq) begin
            m_owner[k] = 1;
            m_kwr[k] = cpu_wr[k]; m_addr[k] = cpu_addr[k]; m_wdata[k] = cpu_wdata[k];
          end
        end
        if (m_owner[k] != 0) begin
          m_t[k] = 1;
          if (m_kwr[k]) m_mem[k][m_addr[k][5:2]] = m_wdata[k];
          else m_rdval[k] = m_mem[k][m_addr[k][5:2]];
        end
      end else begin
        if (m_owner[k] == 1 && dreq && m_sc[k] < 4) m_sc[k]++;
        if (m_t[k] == lat + 1) begin
          m_owner[k] = 0;
        end else begin
          if (m_t[k] == lat && !m_kwr[k]) begin
            if (m_owner[k] == 1) m_cpu_rd[k] = m_rdval[k];
            else m_dbg_rd[k] = m_rdval[k];
          end
          m_t[k]++;
        end
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) model_cycle(k);
    end
  endtask

  task automatic cpu_op(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output int stall_n, output int wr_n, output logic [31:0] rd,
                        output logic [31:0] wr_addr);
    stall_n = 0; wr_n = 0; rd = '0; wr_addr = '0;
    @(posedge clk); #1;
    cpu_rd[k] = !wr; cpu_wr[k] = wr; cpu_addr[k] = a; cpu_wdata[k] = d;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (mem_wr[k]) begin
        wr_n++;
        wr_addr = mem_addr[k];
      end
      if (!cpu_stall[k]) begin
        rd = cpu_rdata[k];
        break;
      end
      stall_n++;
    end
    @(posedge clk); #1;
    cpu_rd[k] = 1'b0; cpu_wr[k] = 1'b0;
  endtask

  task automatic cpu_stream(input int k, input int count, output int stall_tot);
    stall_tot = 0;
    @(posedge clk); #1;
    cpu_rd[k] = 1'b1; cpu_wr[k] = 1'b0;
    for (int a = 0; a < count; a++) begin
      cpu_addr[k] = 32'(a * 4);
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (!cpu_stall[k]) break;
        stall_tot++;
      end
      @(posedge clk); #1;
    end
    cpu_rd[k] = 1'b0;
  endtask

  task automatic dbg_op(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output int ack_n, output logic [31:0] rd);
    ack_n = -1; rd = '0;
    @(posedge clk); #1;
    dbg_req[k] = 1'b1; dbg_wr[k] = wr; dbg_addr[k] = a; dbg_wdata[k] = d;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (dbg_ack[k]) begin
        ack_n = n;
        rd = dbg_rdata[k];
        break;
      end
    end
    @(posedge clk); #1;
    dbg_req[k] = 1'b0;
  endtask

  int          c_st, c_wn, d_ack, s_tot;
  logic [31:0] c_rd, c_wa, d_rd;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; cpu_rd[k] = 1'b0; cpu_wr[k] = 1'b0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
      dbg_req[k] = 1'b0; dbg_wr[k] = 1'b0; dbg_addr[k] = '0; dbg_wdata[k] = '0;
      m_armed[k] = 1'b0; m_owner[k] = 0; m_t[k] = 0; m_sc[k] = 0;
    end
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset cpu_rdata", cpu_rdata[k], 32'h0);
      chk("reset dbg_rdata", dbg_rdata[k], 32'h0);
      chk("reset mem_wr",    32'(mem_wr[k]), 32'h0);
      chk("reset mem_addr",  mem_addr[k], 32'h0);
    end

    // CPU store of 0xEEEE to 0x4, latency 2.
    cpu_op(0, 1'b1, 32'h4, 32'hEEEE, c_st, c_wn, c_rd, c_wa);
    $display("cpu store  @0x4   stall=%0d wr_cycles=%0d wr_addr=%h", c_st, c_wn, c_wa);
    chk("store stall cycles", 32'(c_st), 32'd3);
    chk("store mem_wr cycles", 32'(c_wn), 32'd2);
    chk("store mem_addr", c_wa, 32'h4);
    chk("store memory word1", mem_arr[0][1], 32'hEEEE);

    cpu_op(0, 1'b0, 32'h4, 32'h0, c_st, c_wn, c_rd, c_wa);
    $display("cpu load   @0x4   stall=%0d data=%h", c_st, c_rd);
    chk("load stall cycles", 32'(c_st), 32'd3);
    chk("load data", c_rd, 32'hEEEE);

    // Simultaneous requests below the starvation limit: CPU first, then debug.
    fork
      cpu_op(0, 1'b0, 32'h0, 32'h0, c_st, c_wn, c_rd, c_wa);
      dbg_op(0, 1'b0, 32'h8, 32'h0, d_ack, d_rd);
    join
    $display("collision  cpu@0x0 stall=%0d data=%h  dbg@0x8 ack_cycle=%0d data=%h", c_st, c_rd, d_ack, d_rd);
    chk("collision cpu stall", 32'(c_st), 32'd3);
    chk("collision cpu data", c_rd, 32'hA000);
    chk("collision dbg ack cycle", 32'(d_ack), 32'd7);
    chk("collision dbg data", d_rd, 32'hA002);

    // Back-to-back CPU loads while debug waits; debug must win after 4 waiting cycles.
    fork
      cpu_stream(0, 2, s_tot);
      dbg_op(0, 1'b0, 32'hC, 32'h0, d_ack, d_rd);
    join
    $display("starvation cpu_stall_total=%0d dbg ack_cycle=%0d data=%h", s_tot, d_ack, d_rd);
    chk("starve dbg ack cycle", 32'(d_ack), 32'd7);
    chk("starve dbg data", d_rd, 32'hA003);
    chk("starve cpu stall total", 32'(s_tot), 32'd10);

    // Reset in the second cycle of a CPU write access.
    @(posedge clk); #1;
    cpu_wr[0] = 1'b1; cpu_addr[0] = 32'h10; cpu_wdata[0] = 32'h1234;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    $display("reset mid-access mem_wr=%0b dbg_ack=%0b stall=%0b", mem_wr[0], dbg_ack[0], cpu_stall[0]);
    chk("midreset mem_wr", 32'(mem_wr[0]), 32'h0);
    chk("midreset dbg_ack", 32'(dbg_ack[0]), 32'h0);
    chk("midreset cpu_stall", 32'(cpu_stall[0]), 32'h1);
    chk("midreset cpu_rdata", cpu_rdata[0], 32'h0);
    @(posedge clk); #1;
    rst[0] = 1'b0; cpu_wr[0] = 1'b0;

    // Latency-1 instance: debug write then read back, then a CPU load.
    dbg_op(1, 1'b1, 32'h8, 32'hDDDD, d_ack, d_rd);
    $display("lat1 dbg write @0x8 ack_cycle=%0d", d_ack);
    chk("lat1 dbg write ack cycle", 32'(d_ack), 32'd2);
    dbg_op(1, 1'b0, 32'h8, 32'h0, d_ack, d_rd);
    $display("lat1 dbg read  @0x8 ack_cycle=%0d data=%h", d_ack, d_rd);
    chk("lat1 dbg read ack cycle", 32'(d_ack), 32'd2);
    chk("lat1 dbg read data", d_rd, 32'hDDDD);
    cpu_op(1, 1'b0, 32'h8, 32'h0, c_st, c_wn, c_rd, c_wa);
    $display("lat1 cpu load  @0x8 stall=%0d data=%h", c_st, c_rd);
    chk("lat1 cpu stall", 32'(c_st), 32'd2);
    chk("lat1 cpu data", c_rd, 32'hDDDD);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
